// File: rtl/tx_serializer_pkg.sv
// Shared types and helpers for the tx_serializer block.
// Provides the FSM state encoding, the default word width and the even-parity helper.
package tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    SHIFT,
    GAP,
    DONE
  } tx_state_t;

  localparam int unsigned DefaultDataW = 8;

  // Zero-extended input keeps the XOR result independent of the caller's word width.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/tx_serializer_if.sv
// Word-in / bit-out handshake bundle for tx_serializer.
// The slave modport is the serializer's view; the master modport is its environment.
interface tx_serializer_if
  import tx_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              rx_ready;
  logic              tx_valid;
  logic              tx_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  rx_ready,
    output in_ready,
    output tx_valid,
    output tx_data
  );

  modport master (
    output in_valid,
    output in_data,
    output rx_ready,
    input  in_ready,
    input  tx_valid,
    input  tx_data
  );

endinterface

// File: rtl/tx_serializer.sv
// Parallel-to-serial word transmitter, LSB first, with inter-word gap and frame-done pulse.
// Define TX_PARITY_EN to append an even-parity bit after each word.
module tx_serializer
  import tx_pkg::*;
#(
  parameter int unsigned DATA_W     = DefaultDataW,
  parameter int unsigned NUM_BYTES  = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  tx_serializer_if.slave                 bus,
  output logic                           busy,
  output logic [$clog2(NUM_BYTES+1)-1:0] byte_cnt,
  output logic                           tx_done
);

`ifdef TX_PARITY_EN
  localparam int unsigned ParBits = 1;
`else
  localparam int unsigned ParBits = 0;
`endif

  // One counter serves both the bit index and the gap length.
  localparam int unsigned LastBit = DATA_W - 1 + ParBits;
  localparam int unsigned GapLast = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int unsigned CntMax  = (LastBit > GapLast) ? LastBit : GapLast;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam int unsigned BcW     = $clog2(NUM_BYTES + 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BcW-1:0]    byte_cnt_q, byte_cnt_d;
  logic              tx_valid_q, tx_valid_d;
  logic              tx_data_q, tx_data_d;
  logic              tx_done_q, tx_done_d;
  logic              busy_q, busy_d;
  logic [BcW-1:0]    byte_cnt_inc;
  logic              frame_end;
`ifdef TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign byte_cnt_inc = byte_cnt_q + BcW'(1);
  assign frame_end    = (byte_cnt_q == BcW'(NUM_BYTES));

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_done_d  = 1'b0;
`ifdef TX_PARITY_EN
    par_d      = par_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sr_d    = bus.in_data;
          state_d = WAIT_RDY;
`ifdef TX_PARITY_EN
          par_d   = even_parity(32'(bus.in_data));
`endif
        end
      end

      WAIT_RDY: begin
        if (bus.rx_ready) begin
          tx_valid_d = 1'b1;
          tx_data_d  = sr_q[0];
          sr_d       = sr_q >> 1;
          cnt_d      = '0;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt_q == CntW'(LastBit)) begin
          tx_valid_d = 1'b0;
          tx_data_d  = 1'b0;
          byte_cnt_d = byte_cnt_inc;
          cnt_d      = '0;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
          end else if (byte_cnt_inc == BcW'(NUM_BYTES)) begin
            state_d   = DONE;
            tx_done_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d     = cnt_q + CntW'(1);
          tx_data_d = sr_q[0];
          sr_d      = sr_q >> 1;
`ifdef TX_PARITY_EN
          if (cnt_q == CntW'(DATA_W - 1)) begin
            tx_data_d = par_q;
          end
`endif
        end
      end

      GAP: begin
        if (cnt_q == CntW'(GapLast)) begin
          cnt_d = '0;
          if (frame_end) begin
            state_d   = DONE;
            tx_done_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      DONE: begin
        byte_cnt_d = '0;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      byte_cnt_q <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_done_q  <= tx_done_d;
      busy_q     <= busy_d;
`ifdef TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign bus.in_ready = (state_q == IDLE) && !rst;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign busy         = busy_q;
  assign byte_cnt     = byte_cnt_q;
  assign tx_done      = tx_done_q;

endmodule

// File: doc/tx_serializer.md
Name: tx_serializer

Overview:
Upstream neighbour of the serial receiver (rx). Accepts parallel bytes over a valid/ready handshake and waits for the receiver's rx_ready. It then shifts each byte out LSB-first on tx_data, with tx_valid high for exactly one clock per bit. After NUM_BYTES bytes it pulses tx_done and the frame counter restarts.

Parameters:
- DATA_W, 8, bits per word; legal range 2..32.
- NUM_BYTES, 4, words per frame before tx_done pulses; must be ≥1.
- GAP_CYCLES, 2, idle cycles with tx_valid=0 forced between consecutive words; 0 is legal and means no gap.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream word available.
- in_data  in  DATA_W  upstream word.
- in_ready  out  1  block can accept a word.
- rx_ready  in  1  downstream receiver ready to take a new word.
- tx_valid  out  1  tx_data carries a valid bit this cycle.
- tx_data  out  1  serial bit, LSB first.
- busy  out  1  state is not IDLE.
- byte_cnt  out  $clog2(NUM_BYTES+1)  words sent in the current frame.
- tx_done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset values, applied at the clock edge with rst=1: state=IDLE, tx_valid=0, tx_data=0, byte_cnt=0, tx_done=0, busy=0. The shift register and bit counter are cleared to 0.
- in_ready = (state==IDLE) && !rst. It is combinational.
- All outputs except in_ready are registered.
- IDLE:
  - in_valid && in_ready at edge N loads in_data into the shift register; state becomes WAIT_RDY.
  - in_valid while not in IDLE is ignored; no word is lost because in_ready is low.
- WAIT_RDY:
  - Holds until rx_ready=1 is sampled at edge M.
  - At edge M: tx_valid←1, tx_data←sr[0], bit_idx←0, state→SHIFT.
  - Stays in WAIT_RDY indefinitely if rx_ready stays low.
- SHIFT:
  - Each edge drives the next bit, so bit i is visible during cycle M+i.
  - Exactly DATA_W consecutive cycles of tx_valid=1, with no bubbles.
  - rx_ready changes during SHIFT are ignored; the word always completes.
- End of word: at the edge after the last bit cycle:
  - tx_valid←0, tx_data←0, byte_cnt←byte_cnt+1.
  - If GAP_CYCLES>0: state→GAP.
  - If GAP_CYCLES=0: state→IDLE, or DONE when the frame is complete (see below).
- GAP: counts GAP_CYCLES cycles with tx_valid=0, then goes to IDLE, or to DONE if byte_cnt==NUM_BYTES.
- DONE:
  - Lasts one cycle: tx_done=1, byte_cnt←0, then state→IDLE.
  - in_ready is low during DONE.
- Minimum per-word occupancy, from accept to next in_ready: 1 (WAIT_RDY, when rx_ready is already high) + DATA_W + GAP_CYCLES (+1 for DONE on the last word).
- busy=1 in every state except IDLE.
- rst asserted mid-word: at that edge everything returns to reset values. The partial word is discarded and tx_valid=0 from the next cycle onward.
- byte_cnt never exceeds NUM_BYTES; it wraps to 0 only through DONE.

Optional Feature:
- Macro TX_PARITY_EN.
- When defined: after the DATA_W data bits, one extra cycle with tx_valid=1 and tx_data=^word, the even-parity bit. byte_cnt increments after the parity cycle, and per-word occupancy grows by 1.
- When undefined: no parity cycle, and tx_valid is high for exactly DATA_W cycles per word.

Decomposition:
- Package tx_pkg holds:
  - typedef enum logic [2:0] {IDLE, WAIT_RDY, SHIFT, GAP, DONE} tx_state_t;
  - localparam default DATA_W;
  - function even_parity(word).
- No sub-module is required: the bit and gap counters share one counter inside tx_serializer.

Test Plan:
- Single word: rx_ready held 1, in_data=8'hD5 → over 8 consecutive cycles tx_valid=1 and tx_data = 1,0,1,0,1,0,1,1; then byte_cnt=1 and tx_valid=0 for 2 gap cycles.
- Frame: words 8'hD5, 8'h33, 8'hAA, 8'hF0 back-to-back → four 8-bit bursts separated by 2-cycle gaps; tx_done pulses high for exactly 1 cycle after the fourth word; byte_cnt then reads 0.
- Backpressure: rx_ready=0 for 10 cycles after accepting 8'h0F → tx_valid stays 0 and in_ready stays 0; when rx_ready rises, the burst 1,1,1,1,0,0,0,0 starts on the next cycle.
- rx_ready drops at bit 3 of 8'hAA → all 8 bits are still sent contiguously (0,1,0,1,0,1,0,1).
- Reset mid-word: rst=1 during bit 4 of 8'hFF → next cycle tx_valid=0, byte_cnt=0, in_ready=1; a following 8'h01 is sent correctly.
- With TX_PARITY_EN defined, 8'h07 → bits 1,1,1,0,0,0,0,0 followed by parity bit 1, giving 9 cycles of tx_valid=1.
